// File: rtl/mgs_stream_driver.sv
// rtl/mgs_stream_driver.sv - self-test sequencer and AXIS traffic endpoint for the magic streamer
module mgs_stream_driver #(
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    burst_len,
    input  logic [DATA_WIDTH-1:0]   seed,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [LEN_WIDTH-1:0]    err_count,
    output logic [DATA_WIDTH-1:0]   M_AXI_TDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_TKEEP,
    output logic                    M_AXI_TVALID,
    input  logic                    M_AXI_TREADY,
    output logic                    M_AXI_TLAST,
    input  logic [DATA_WIDTH-1:0]   S_AXI_TDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_TKEEP,
    input  logic                    S_AXI_TVALID,
    output logic                    S_AXI_TREADY,
    input  logic                    S_AXI_TLAST,
    output logic                    storeReset,
    output logic                    loadReset,
    output logic                    storeInit,
    output logic                    loadInit,
    input  logic                    finStore
);

    localparam int WAIT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SRST, S_LRST, S_SINIT, S_SEND, S_WFIN, S_LINIT, S_RECV, S_DONE
    } state_t;

    state_t state, state_next;

    logic [LEN_WIDTH-1:0]  len_q, tx_cnt, rx_cnt, err_q, err_inc, err_next;
    logic [DATA_WIDTH-1:0] seed_q, tx_word, rx_expect;
    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic                  pass_q, timeout_q;
    logic                  start_ok, tx_fire, rx_fire, tx_last, rx_last, rx_bad;
    logic                  wait_expired, timeout_hit;
    logic                  unused_keep;

    // Load-port byte enables carry no information for this check.
    assign unused_keep = ^S_AXI_TKEEP;

    assign start_ok     = start && (burst_len != '0);
    assign tx_word      = seed_q + DATA_WIDTH'(tx_cnt);
    assign rx_expect    = seed_q + DATA_WIDTH'(rx_cnt);
    assign tx_last      = (tx_cnt == len_q - LEN_WIDTH'(1));
    assign rx_last      = (rx_cnt == len_q - LEN_WIDTH'(1));
    assign tx_fire      = (state == S_SEND) && M_AXI_TREADY;
    assign rx_fire      = (state == S_RECV) && S_AXI_TVALID;
    // Data and framing faults on one beat count as a single error.
    assign rx_bad       = (S_AXI_TDATA != rx_expect) || (S_AXI_TLAST != rx_last);
    assign err_inc      = (err_q == '1) ? err_q : err_q + LEN_WIDTH'(1);
    assign err_next     = (rx_fire && rx_bad) ? err_inc : err_q;
    assign wait_expired = (wait_cnt == WAIT_LAST);

    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign err_count   = err_q;
    assign M_AXI_TKEEP = '1;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next   = state;
        timeout_hit  = 1'b0;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        storeReset   = 1'b0;
        loadReset    = 1'b0;
        storeInit    = 1'b0;
        loadInit     = 1'b0;
        M_AXI_TVALID = 1'b0;
        M_AXI_TDATA  = '0;
        M_AXI_TLAST  = 1'b0;
        S_AXI_TREADY = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) state_next = S_SRST;
            end
            S_SRST: begin
                storeReset = 1'b1;
                state_next = S_LRST;
            end
            S_LRST: begin
                loadReset  = 1'b1;
                state_next = S_SINIT;
            end
            S_SINIT: begin
                storeInit  = 1'b1;
                state_next = S_SEND;
            end
            S_SEND: begin
                M_AXI_TVALID = 1'b1;
                M_AXI_TDATA  = tx_word;
                M_AXI_TLAST  = tx_last;
                if (tx_fire && tx_last) state_next = S_WFIN;
            end
            S_WFIN: begin
                if (finStore) begin
                    state_next = S_LINIT;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = S_DONE;
                end
            end
            S_LINIT: begin
                loadInit   = 1'b1;
                state_next = S_RECV;
            end
            S_RECV: begin
                S_AXI_TREADY = 1'b1;
                if (rx_fire) begin
                    if (rx_last) state_next = S_DONE;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Run context, beat counters, idle watchdog and result flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q     <= '0;
            seed_q    <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            err_q     <= '0;
            wait_cnt  <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        len_q     <= burst_len;
                        seed_q    <= seed;
                        tx_cnt    <= '0;
                        rx_cnt    <= '0;
                        err_q     <= '0;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                S_SEND: begin
                    wait_cnt <= '0;
                    if (tx_fire) tx_cnt <= tx_cnt + LEN_WIDTH'(1);
                end
                S_WFIN: begin
                    wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
                end
                S_LINIT: begin
                    wait_cnt <= '0;
                end
                S_RECV: begin
                    err_q <= err_next;
                    if (rx_fire) begin
                        rx_cnt   <= rx_cnt + LEN_WIDTH'(1);
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
            if (timeout_hit) timeout_q <= 1'b1;
            // Verdict lands on the edge into DONE so it is valid alongside the done pulse.
            if (state_next == S_DONE && state != S_DONE) begin
                pass_q <= !timeout_hit && (err_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_mgs_stream_driver.sv
// tb/tb_mgs_stream_driver.sv - directed self-checking bench for mgs_stream_driver
module tb_mgs_stream_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  burst_len = '0;
    logic [31:0] seed = '0;
    logic        busy, done, pass, timeout;
    logic [9:0]  err_count;
    logic [31:0] M_AXI_TDATA;
    logic [3:0]  M_AXI_TKEEP;
    logic        M_AXI_TVALID, M_AXI_TLAST;
    logic        M_AXI_TREADY = 1'b0;
    logic [31:0] S_AXI_TDATA = '0;
    logic [3:0]  S_AXI_TKEEP = '0;
    logic        S_AXI_TVALID = 1'b0;
    logic        S_AXI_TLAST = 1'b0;
    logic        S_AXI_TREADY;
    logic        storeReset, loadReset, storeInit, loadInit;
    logic        finStore = 1'b0;
    logic [3:0]  pulses;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] store_q[$];

    assign pulses = {storeReset, loadReset, storeInit, loadInit};

    always #5 clk = ~clk;

    mgs_stream_driver dut (
        .clk(clk), .reset(reset), .start(start), .burst_len(burst_len), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .M_AXI_TDATA(M_AXI_TDATA), .M_AXI_TKEEP(M_AXI_TKEEP), .M_AXI_TVALID(M_AXI_TVALID),
        .M_AXI_TREADY(M_AXI_TREADY), .M_AXI_TLAST(M_AXI_TLAST),
        .S_AXI_TDATA(S_AXI_TDATA), .S_AXI_TKEEP(S_AXI_TKEEP), .S_AXI_TVALID(S_AXI_TVALID),
        .S_AXI_TREADY(S_AXI_TREADY), .S_AXI_TLAST(S_AXI_TLAST),
        .storeReset(storeReset), .loadReset(loadReset), .storeInit(storeInit),
        .loadInit(loadInit), .finStore(finStore)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic kick(input logic [9:0] len, input logic [31:0] sd);
        burst_len = len;
        seed      = sd;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Control pulse order through SRST/LRST/SINIT; ends at the first SEND cycle.
    task automatic preamble(input string nm);
        check_eq({nm, ".srst"}, 64'({busy, pulses}), 64'(5'b1_1000));
        @(negedge clk);
        check_eq({nm, ".lrst"}, 64'(pulses), 64'(4'b0100));
        @(negedge clk);
        check_eq({nm, ".sinit"}, 64'(pulses), 64'(4'b0010));
        @(negedge clk);
        check_eq({nm, ".first_valid"}, 64'(M_AXI_TVALID), 64'(1));
    endtask

    // Store-port sink: 1010.. ready pattern when stalled; checks every presented beat.
    task automatic send_beats(input string nm, input int len, input logic [31:0] sd,
                              input bit stall, input bit hold_start);
        int cnt = 0;
        int cyc = 0;
        logic rdy;
        logic [31:0] exp_w;
        store_q.delete();
        if (hold_start) begin
            burst_len = 10'd7;
            start     = 1'b1;
        end
        while (cyc < 64) begin
            if (!M_AXI_TVALID) break;
            rdy = stall ? (cyc % 2 == 0) : 1'b1;
            M_AXI_TREADY = rdy;
            exp_w = sd + 32'(cnt);
            check_eq($sformatf("%s.tdata%0d", nm, cyc), 64'(M_AXI_TDATA), 64'(exp_w));
            check_eq($sformatf("%s.tlast%0d", nm, cyc), 64'(M_AXI_TLAST), 64'(cnt == len - 1));
            if (rdy) begin
                store_q.push_back(M_AXI_TDATA);
                cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        M_AXI_TREADY = 1'b0;
        start        = 1'b0;
        check_eq({nm, ".tx_beats"}, 64'(cnt), 64'(len));
    endtask

    // Load-port source: replays stored words with optional injected faults.
    task automatic recv_beats(input string nm, input int len, input int bad_data, input int bad_last);
        int i = 0;
        int cyc = 0;
        while (i < len && cyc < 64) begin
            if (S_AXI_TREADY) begin
                S_AXI_TVALID = 1'b1;
                S_AXI_TDATA  = (i < store_q.size()) ? store_q[i] : 32'h0;
                if (i == bad_data) S_AXI_TDATA[0] = ~S_AXI_TDATA[0];
                S_AXI_TLAST  = (i == len - 1) && (i != bad_last);
                i++;
            end else begin
                S_AXI_TVALID = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        S_AXI_TVALID = 1'b0;
        S_AXI_TLAST  = 1'b0;
        check_eq({nm, ".rx_beats"}, 64'(i), 64'(len));
    endtask

    task automatic full_run(input string nm, input int len, input logic [31:0] sd, input bit stall,
                            input bit hold_start, input int bad_data, input int bad_last,
                            input int exp_err);
        kick(10'(len), sd);
        preamble(nm);
        send_beats(nm, len, sd, stall, hold_start);
        check_eq({nm, ".wfin1"}, 64'({busy, pulses}), 64'(5'b1_0000));
        @(negedge clk);
        check_eq({nm, ".wfin2"}, 64'(loadInit), 64'(0));
        finStore = 1'b1;
        @(negedge clk);
        finStore = 1'b0;
        check_eq({nm, ".linit"}, 64'(pulses), 64'(4'b0001));
        @(negedge clk);
        recv_beats(nm, len, bad_data, bad_last);
        check_eq({nm, ".done"}, 64'({done, pass, timeout}), 64'({1'b1, exp_err == 0, 1'b0}));
        check_eq({nm, ".err"}, 64'(err_count), 64'(exp_err));
        @(negedge clk);
        check_eq({nm, ".idle"}, 64'({busy, done, pass}), 64'({2'b00, exp_err == 0}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst.status", 64'({busy, done, pass, timeout, err_count}), 64'(0));
        check_eq("rst.axis", 64'({M_AXI_TVALID, M_AXI_TLAST, M_AXI_TDATA, S_AXI_TREADY}), 64'(0));
        check_eq("rst.tkeep", 64'(M_AXI_TKEEP), 64'(4'hF));
        check_eq("rst.pulses", 64'(pulses), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        // Ideal loopback: words 0x10..0x13.
        full_run("ideal", 4, 32'h10, 1'b0, 1'b0, -1, -1, 0);
        check_eq("ideal.word3", 64'(store_q[3]), 64'(32'h13));

        // Backpressure with start held high during SEND (must not relatch len=7).
        full_run("bp", 3, 32'h200, 1'b1, 1'b1, -1, -1, 0);

        // Corruption with data wrap: FFFFFFFE, FFFFFFFF, 0, 1, 2.
        full_run("corrupt", 5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 4, 2);
        check_eq("corrupt.wrap", 64'(store_q[2]), 64'(32'h0));

        // Timeout in WFIN: DONE follows the 1024th WFIN cycle.
        begin
            bit seen_li = 1'b0;
            kick(10'd1, 32'h55);
            preamble("to");
            send_beats("to", 1, 32'h55, 1'b0, 1'b0);
            if (loadInit) seen_li = 1'b1;
            repeat (1023) begin
                @(negedge clk);
                if (loadInit) seen_li = 1'b1;
            end
            check_eq("to.still_wait", 64'({busy, done, timeout}), 64'(3'b100));
            @(negedge clk);
            check_eq("to.done", 64'({done, pass, timeout}), 64'(3'b101));
            check_eq("to.no_loadinit", 64'(seen_li), 64'(0));
            @(negedge clk);
            check_eq("to.held", 64'({busy, done, timeout}), 64'(3'b001));
        end

        // Zero length start is ignored; previous result stays held.
        kick(10'd0, 32'h1);
        check_eq("len0.idle", 64'({busy, pulses}), 64'(0));
        @(negedge clk);
        check_eq("len0.held", 64'({busy, timeout, pass}), 64'(3'b010));

        // Asynchronous reset in the middle of SEND.
        kick(10'd3, 32'h5);
        repeat (3) @(negedge clk);
        check_eq("arst.pre", 64'(M_AXI_TVALID), 64'(1));
        #2 reset = 1'b0;
        #1;
        check_eq("arst.status", 64'({busy, done, pass, timeout, err_count}), 64'(0));
        check_eq("arst.axis", 64'({M_AXI_TVALID, M_AXI_TLAST, M_AXI_TDATA}), 64'(0));
        check_eq("arst.tkeep", 64'(M_AXI_TKEEP), 64'(4'hF));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        full_run("recover", 2, 32'hA0, 1'b0, 1'b0, -1, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
